// File: rtl/corespi_bfm_apbslave_mem_if.sv
// APB bus bundle for the CoreSPI BFM memory slave. Clock and reset are not
// carried here; they stay plain ports on the slave.
interface corespi_bfm_apbslave_mem_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        PROT_ERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR, PROT_ERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR, PROT_ERR
  );
endinterface

// File: rtl/corespi_bfm_apbslave_mem.sv
// APB slave memory model with programmable wait states, out-of-range error
// response and a sticky protocol-violation flag.
module corespi_bfm_apbslave_mem #(
  parameter int AWIDTH     = 10,
  parameter int WAITCYCLES = 0,
  parameter int TPD        = 1
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  corespi_bfm_apbslave_mem_if.slave     apb
);

  localparam int         DEPTH     = 1 << AWIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAITCYCLES);

  // TPD only models output delay in simulation models; here it is range-checked.
  if (AWIDTH < 1 || AWIDTH > 29 || WAITCYCLES < 0 || WAITCYCLES > 15 || TPD < 0) begin : g_param_check
    $error("corespi_bfm_apbslave_mem: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic [31:0]         addr_r;
  logic [31:0]         wdata_r;
  logic                write_r;
  logic                prot_err_r;
  logic                capture_s;
  logic                prot_set_s;
  logic                wr_en_s;
  logic                pready_s;
  logic                in_range_s;
  logic                mismatch_s;
  logic [AWIDTH-1:0]   index_s;
  logic [31:0]         mem_r [DEPTH];

  // Decode of the captured address and the wait-state status.
  always_comb begin
    pready_s   = (state_r == ACCESS) && (cnt_r == 4'd0);
    in_range_s = ((addr_r >> (AWIDTH + 2)) == 32'd0);
    index_s    = addr_r[AWIDTH+1:2];
    mismatch_s = (apb.PADDR != addr_r) || (apb.PWRITE != write_r) ||
                 (write_r && (apb.PWDATA != wdata_r));
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    prot_set_s  = 1'b0;
    wr_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_nxt_s = SETUP;
          capture_s   = 1'b1;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          prot_set_s  = apb.PENABLE;
        end
      end
      SETUP: begin
        if (!apb.PSEL) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (!apb.PENABLE) begin
          state_nxt_s = SETUP;
          capture_s   = 1'b1;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      ACCESS: begin
        if (!apb.PSEL || !apb.PENABLE) begin
          // Abandoned transfer: flag it and drop the access without a write.
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
          prot_set_s  = 1'b1;
        end else if (pready_s) begin
          state_nxt_s = IDLE;
          wr_en_s     = write_r && in_range_s;
          prot_set_s  = mismatch_s;
        end else begin
          state_nxt_s = ACCESS;
          cnt_nxt_s   = cnt_r - 4'd1;
          prot_set_s  = mismatch_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // FSM state, wait counter, captured transfer and sticky error flag.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      write_r    <= 1'b0;
      prot_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (capture_s) begin
        addr_r  <= apb.PADDR;
        wdata_r <= apb.PWDATA;
        write_r <= apb.PWRITE;
      end
      if (prot_set_s) begin
        prot_err_r <= 1'b1;
      end
    end
  end

  // Memory array; reset wipes every word so a pending write cannot survive.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      mem_r[index_s] <= wdata_r;
    end
  end

  // Bus responses are combinational so PREADY reflects the counter directly.
  always_comb begin
    apb.PREADY   = pready_s;
    apb.PSLVERR  = pready_s && !in_range_s;
    apb.PROT_ERR = prot_err_r;
    if (pready_s && !write_r && in_range_s) begin
      apb.PRDATA = mem_r[index_s];
    end else begin
      apb.PRDATA = 32'd0;
    end
  end

endmodule
